// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, default widths
// and the bit positions of the decoder fields inside a 32-bit instruction.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_RESET_PC = 0;

  // Decoder field layout of a 32-bit instruction word
  localparam int F_DATA_MSB   = 31;
  localparam int F_DATA_LSB   = 16;
  localparam int F_ADDR1_MSB  = 15;
  localparam int F_ADDR1_LSB  = 11;
  localparam int F_READ_BIT   = 10;
  localparam int F_WRITE_BIT  = 9;
  localparam int F_LDI_BIT    = 8;
  localparam int F_OPCODE_MSB = 7;
  localparam int F_OPCODE_LSB = 4;
  localparam int F_FLAGS_MSB  = 3;
  localparam int F_FLAGS_LSB  = 0;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: a redirect load wins over the post-fetch increment,
// and the increment wraps modulo 2^ADDR_W.
module instr_fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_addr;
    end else if (inc_en) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: single-outstanding instruction memory requests, one-entry
// instruction register toward the decoder, branch redirect and halt.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               pc_load;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc_cur;

  instr_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (pc_load),
    .load_addr (branch_target),
    .inc_en    (pc_inc),
    .pc        (pc_cur)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (branch_en) begin
          pc_load = 1'b1;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A redirect discards any word returned in the same cycle; without an
        // ack the request drops for one cycle before restarting at the target.
        if (branch_en) begin
          pc_load = 1'b1;
          if (!imem_ack) begin
            state_d = ST_IDLE;
          end
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          pc_inc        = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (branch_en) begin
          instr_valid_d = 1'b0;
          pc_load       = 1'b1;
          state_d       = ST_REQ;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = halt ? ST_HALTED : ST_REQ;
        end
      end
      ST_HALTED: begin
        if (branch_en) begin
          pc_load = 1'b1;
        end else if (!halt) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_cur;
  assign pc          = pc_cur;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the fetch stage.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic        halt;
  logic [7:0]  pc;
  logic        halted;

  instr_fetch #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .halt          (halt),
    .pc            (pc),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [256];

  // Model of the stage: exactly one of fresh/waiting/halted/holding applies.
  // fresh = the single idle cycle, waiting = request outstanding,
  // holding = an instruction is buffered for the decoder.
  int          m_pc;
  logic [31:0] m_instr;
  logic        m_valid, m_fresh, m_waiting, m_halted;
  int          wait_cnt, wait_lo, wait_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req",    {31'b0, imem_req},    {31'b0, m_waiting});
    chk("imem_addr",   {24'b0, imem_addr},   m_pc);
    chk("pc",          {24'b0, pc},          m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("instr",       instr,                m_instr);
    chk("halted",      {31'b0, halted},      {31'b0, m_halted});
  endtask

  task automatic m_reset();
    m_pc = 0; m_instr = '0; m_valid = 1'b0;
    m_fresh = 1'b1; m_waiting = 1'b0; m_halted = 1'b0;
    wait_cnt = 0;
  endtask

  task automatic tick(input logic rdy, input logic hlt, input logic br, input logic [7:0] tgt);
    logic        ack;
    logic [31:0] rd;
    logic        prev_wait;
    ack = m_waiting && (wait_cnt == 0);
    rd  = ack ? mem[m_pc] : $urandom;
    instr_ready = rdy; halt = hlt; branch_en = br; branch_target = tgt;
    imem_ack = ack; imem_rdata = rd;
    @(posedge clk);
    prev_wait = m_waiting;
    if (m_fresh) begin
      if (br) m_pc = int'(tgt);
      else begin
        m_fresh = 1'b0;
        if (hlt) m_halted = 1'b1; else m_waiting = 1'b1;
      end
    end else if (m_waiting) begin
      if (br) begin
        m_pc = int'(tgt);
        if (!ack) begin m_waiting = 1'b0; m_fresh = 1'b1; end
      end else if (ack) begin
        m_instr = rd; m_valid = 1'b1; m_pc = (m_pc + 1) % 256; m_waiting = 1'b0;
      end
    end else if (m_halted) begin
      if (br) m_pc = int'(tgt);
      else if (!hlt) begin m_halted = 1'b0; m_waiting = 1'b1; end
    end else begin
      if (br) begin
        m_valid = 1'b0; m_pc = int'(tgt); m_waiting = 1'b1;
      end else if (rdy) begin
        m_valid = 1'b0;
        if (hlt) m_halted = 1'b1; else m_waiting = 1'b1;
      end
    end
    if (m_waiting && (!prev_wait || ack)) wait_cnt = int'($urandom_range(wait_hi, wait_lo));
    else if (m_waiting && wait_cnt > 0) wait_cnt--;
    #1;
    check_all();
  endtask

  task automatic wait_hold();
    for (int i = 0; i < 50 && !(m_valid && !m_waiting); i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wait_hold_timeout", {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    logic hlt_r;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'hA5A5_0123;
    wait_lo = 0; wait_hi = 0;
    instr_ready = 1'b1; halt = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
    imem_ack = 1'b0; imem_rdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    check_all();
    chk("reset_instr", instr, 32'h0);

    // Release reset: one idle cycle, then fetch of address 0
    rst_n = 1'b1;
    chk("idle_no_req", {31'b0, imem_req}, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", {24'b0, imem_addr}, 32'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("first_instr", instr, 32'hA5A5_0123);
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_pc", {24'b0, pc}, 32'h01);

    // Three wait states with the decoder stalled
    wait_lo = 3; wait_hi = 3;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      chk("wait_req_stable", {31'b0, imem_req}, 32'd1);
      chk("wait_addr_stable", {24'b0, imem_addr}, 32'h01);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      chk("hold_no_req", {31'b0, imem_req}, 32'd0);
      chk("hold_instr", instr, mem[1]);
    end
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    // PC wrap at 8'hFF
    wait_lo = 0; wait_hi = 0;
    wait_hold();
    tick(1'b1, 1'b0, 1'b1, 8'hFF);
    chk("wrap_target", {24'b0, imem_addr}, 32'hFF);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap_pc", {24'b0, pc}, 32'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("wrap_addr", {24'b0, imem_addr}, 32'h00);

    // Branch flushes a held instruction, then branch in an ack cycle
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b1, 8'h40);
    chk("flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("flush_addr", {24'b0, imem_addr}, 32'h40);
    tick(1'b1, 1'b0, 1'b1, 8'h40);
    chk("discard_valid", {31'b0, instr_valid}, 32'd0);
    chk("discard_pc", {24'b0, pc}, 32'h40);
    chk("discard_req", {31'b0, imem_req}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("branch_instr", instr, mem[8'h40]);

    // Halt raised while a request is outstanding
    wait_lo = 2; wait_hi = 2;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 8'h00);
    chk("halt_delivered", {31'b0, instr_valid}, 32'd1);
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    chk("halted", {31'b0, halted}, 32'd1);
    chk("halted_no_req", {31'b0, imem_req}, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", {24'b0, imem_addr}, 32'h42);

    // Asynchronous reset in the middle of a request, late ack ignored
    wait_lo = 3; wait_hi = 3;
    wait_hold();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    chk("async_rst_instr", instr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    wait_lo = 0; wait_hi = 0;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("restart_addr", {24'b0, imem_addr}, 32'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("restart_instr", instr, 32'hA5A5_0123);

    // Random traffic
    wait_lo = 0; wait_hi = 3;
    hlt_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) hlt_r = ~hlt_r;
      tick(1'($urandom_range(0, 1)), hlt_r, ($urandom_range(0, 11) == 0), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
